// File: rtl/ddr_fsw_seq.sv
// DDR PHY frequency-switch sequencer: prepare, gate the clock, swap the VCO,
// wait for PLL lock (with timeout), ungate, then hand back an acknowledge.
//
// state  | meaning
// IDLE   | waiting for a switch request
// PREP   | pre-gate settle, i_prep_cnt+1 cycles
// GATE   | clock stopped, i_pre_cnt+1 cycles before the swap
// SWITCH | VCO select updated, one cycle
// LOCK   | waiting for PLL lock, at most i_lock_to+1 cycles
// UNGATE | clock running again, i_post_cnt+1 cycles
// ACK    | switch done, held until the request drops
module ddr_fsw_seq #(
  parameter int CNT_W = 8,
  parameter int TO_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req,
  input  logic             i_req_vco_sel,
  input  logic [CNT_W-1:0] i_prep_cnt,
  input  logic [CNT_W-1:0] i_pre_cnt,
  input  logic [CNT_W-1:0] i_post_cnt,
  input  logic [TO_W-1:0]  i_lock_to,
  input  logic             i_pll_lock,
  input  logic             i_err_clr,
  output logic             o_clk_gate,
  output logic             o_vco_sel,
  output logic             o_ack,
  output logic             o_busy,
  output logic             o_lock_err,
  output logic [2:0]       o_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREP   = 3'd1,
    S_GATE   = 3'd2,
    S_SWITCH = 3'd3,
    S_LOCK   = 3'd4,
    S_UNGATE = 3'd5,
    S_ACK    = 3'd6
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             tgt;

  assign o_state = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      to_cnt     <= '0;
      tgt        <= 1'b0;
      o_clk_gate <= 1'b0;
      o_vco_sel  <= 1'b0;
      o_ack      <= 1'b0;
      o_busy     <= 1'b0;
      o_lock_err <= 1'b0;
    end else begin
      // A timeout in LOCK below overrides this clear, so set wins.
      if (i_err_clr) o_lock_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (i_req) begin
            tgt    <= i_req_vco_sel;
            o_busy <= 1'b1;
            if (i_req_vco_sel == o_vco_sel) begin
              state <= S_ACK;
              o_ack <= 1'b1;
            end else begin
              state <= S_PREP;
              cnt   <= i_prep_cnt;
            end
          end
        end
        S_PREP: begin
          if (cnt == '0) begin
            state      <= S_GATE;
            cnt        <= i_pre_cnt;
            o_clk_gate <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_GATE: begin
          if (cnt == '0) begin
            state     <= S_SWITCH;
            o_vco_sel <= tgt;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_SWITCH: begin
          state  <= S_LOCK;
          to_cnt <= i_lock_to;
        end
        S_LOCK: begin
          // Lock is checked first so a lock on the final count is not an error.
          if (i_pll_lock || to_cnt == '0) begin
            state      <= S_UNGATE;
            cnt        <= i_post_cnt;
            o_clk_gate <= 1'b0;
            if (!i_pll_lock) o_lock_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt - TO_W'(1);
          end
        end
        S_UNGATE: begin
          if (cnt == '0) begin
            state <= S_ACK;
            o_ack <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_ACK: begin
          if (!i_req) begin
            state  <= S_IDLE;
            o_ack  <= 1'b0;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          o_clk_gate <= 1'b0;
          o_ack      <= 1'b0;
          o_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_fsw_seq.sv
// Directed bench for ddr_fsw_seq; expected timelines are hand-derived cycle tables.
module tb_ddr_fsw_seq;
  logic        i_clk;
  logic        i_rst_n;
  logic        i_req;
  logic        i_req_vco_sel;
  logic [7:0]  i_prep_cnt;
  logic [7:0]  i_pre_cnt;
  logic [7:0]  i_post_cnt;
  logic [15:0] i_lock_to;
  logic        i_pll_lock;
  logic        i_err_clr;
  logic        o_clk_gate;
  logic        o_vco_sel;
  logic        o_ack;
  logic        o_busy;
  logic        o_lock_err;
  logic [2:0]  o_state;

  int tests;
  int failed;

  ddr_fsw_seq dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_req         (i_req),
    .i_req_vco_sel (i_req_vco_sel),
    .i_prep_cnt    (i_prep_cnt),
    .i_pre_cnt     (i_pre_cnt),
    .i_post_cnt    (i_post_cnt),
    .i_lock_to     (i_lock_to),
    .i_pll_lock    (i_pll_lock),
    .i_err_clr     (i_err_clr),
    .o_clk_gate    (o_clk_gate),
    .o_vco_sel     (o_vco_sel),
    .o_ack         (o_ack),
    .o_busy        (o_busy),
    .o_lock_err    (o_lock_err),
    .o_state       (o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) tick();
    tests++;
    if ({o_clk_gate, o_vco_sel, o_ack, o_busy, o_lock_err} !== 5'b0) begin
      failed++;
      $display("FAIL reset_outputs got %b exp 00000",
               {o_clk_gate, o_vco_sel, o_ack, o_busy, o_lock_err});
    end
    tests++;
    if (o_state !== 3'd0) begin
      failed++; $display("FAIL reset_state got %0d exp 0", o_state);
    end
    i_rst_n = 1'b1;
    repeat (2) tick();
    tests++;
    if (o_state !== 3'd0 || o_busy !== 1'b0) begin
      failed++; $display("FAIL reset_idle state %0d busy %b exp 0 0", o_state, o_busy);
    end
  endtask

  task automatic test_same_vco();
    i_req_vco_sel = 1'b0;
    i_req = 1'b1;
    tick();
    tests++;
    if (o_state !== 3'd6 || o_ack !== 1'b1 || o_busy !== 1'b1) begin
      failed++;
      $display("FAIL same_vco_ack state %0d ack %b busy %b exp 6 1 1", o_state, o_ack, o_busy);
    end
    repeat (2) tick();
    tests++;
    if (o_clk_gate !== 1'b0 || o_vco_sel !== 1'b0 || o_ack !== 1'b1) begin
      failed++;
      $display("FAIL same_vco_hold gate %b vco %b ack %b exp 0 0 1", o_clk_gate, o_vco_sel, o_ack);
    end
    i_req = 1'b0;
    tick();
    tests++;
    if (o_ack !== 1'b0 || o_busy !== 1'b0 || o_state !== 3'd0) begin
      failed++;
      $display("FAIL same_vco_release ack %b busy %b state %0d exp 0 0 0", o_ack, o_busy, o_state);
    end
  endtask

  task automatic test_full_switch();
    logic [2:0] exp_st;
    int gate_cycles;
    gate_cycles = 0;
    i_prep_cnt = 8'd2; i_pre_cnt = 8'd1; i_post_cnt = 8'd3; i_lock_to = 16'd10;
    i_pll_lock = 1'b0;
    i_req_vco_sel = 1'b1;
    i_req = 1'b1;
    for (int t = 0; t <= 13; t++) begin
      tick();
      exp_st = (t < 3) ? 3'd1 : (t < 5) ? 3'd2 : (t == 5) ? 3'd3 :
               (t < 9) ? 3'd4 : (t < 13) ? 3'd5 : 3'd6;
      tests++;
      if (o_state !== exp_st || o_clk_gate !== (exp_st inside {3'd2, 3'd3, 3'd4}) ||
          o_vco_sel !== (t >= 5) || o_ack !== (t == 13) || o_busy !== 1'b1) begin
        failed++;
        $display("FAIL full_t%0d state %0d gate %b vco %b ack %b busy %b exp state %0d",
                 t, o_state, o_clk_gate, o_vco_sel, o_ack, o_busy, exp_st);
      end
      if (o_clk_gate) gate_cycles++;
      if (t == 8) i_pll_lock = 1'b1;
    end
    tests++;
    if (gate_cycles != 6 || o_lock_err !== 1'b0) begin
      failed++;
      $display("FAIL full_gate_width got %0d err %b exp 6 0", gate_cycles, o_lock_err);
    end
    i_req = 1'b0;
    i_pll_lock = 1'b0;
    tick();
    tests++;
    if (o_ack !== 1'b0 || o_busy !== 1'b0 || o_state !== 3'd0) begin
      failed++;
      $display("FAIL full_release ack %b busy %b state %0d exp 0 0 0", o_ack, o_busy, o_state);
    end
  endtask

  task automatic test_lock_timeout();
    logic [2:0] exp_st;
    i_prep_cnt = 8'd0; i_pre_cnt = 8'd0; i_post_cnt = 8'd0; i_lock_to = 16'd4;
    i_pll_lock = 1'b0;
    i_req_vco_sel = 1'b0;
    i_req = 1'b1;
    for (int t = 0; t <= 9; t++) begin
      tick();
      exp_st = (t == 0) ? 3'd1 : (t == 1) ? 3'd2 : (t == 2) ? 3'd3 :
               (t < 8) ? 3'd4 : (t == 8) ? 3'd5 : 3'd6;
      tests++;
      if (o_state !== exp_st || o_lock_err !== (t >= 8)) begin
        failed++;
        $display("FAIL timeout_t%0d state %0d err %b exp %0d %b", t, o_state, o_lock_err, exp_st, t >= 8);
      end
    end
    i_req = 1'b0;
    tick();
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    tests++;
    if (o_lock_err !== 1'b0) begin
      failed++; $display("FAIL err_clear got %b exp 0", o_lock_err);
    end
    // Clear held high across the timeout edge: the set must win.
    i_err_clr = 1'b1;
    i_req_vco_sel = 1'b1;
    i_req = 1'b1;
    for (int t = 0; t <= 8; t++) begin
      tick();
      if (t == 7) begin
        tests++;
        if (o_lock_err !== 1'b0 || o_state !== 3'd4) begin
          failed++; $display("FAIL set_clr_pre err %b state %0d exp 0 4", o_lock_err, o_state);
        end
      end
    end
    tests++;
    if (o_lock_err !== 1'b1 || o_state !== 3'd5) begin
      failed++; $display("FAIL set_clr_same err %b state %0d exp 1 5", o_lock_err, o_state);
    end
    i_err_clr = 1'b0;
    tick();
    tests++;
    if (o_lock_err !== 1'b1 || o_ack !== 1'b1) begin
      failed++; $display("FAIL set_clr_after err %b ack %b exp 1 1", o_lock_err, o_ack);
    end
    i_req = 1'b0;
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    tests++;
    if (o_lock_err !== 1'b0 || o_state !== 3'd0) begin
      failed++; $display("FAIL err_clear2 err %b state %0d exp 0 0", o_lock_err, o_state);
    end
  endtask

  task automatic test_lock_boundary();
    i_prep_cnt = 8'd0; i_pre_cnt = 8'd0; i_post_cnt = 8'd0; i_lock_to = 16'd2;
    i_pll_lock = 1'b0;
    i_req_vco_sel = 1'b0;
    i_req = 1'b1;
    for (int t = 0; t <= 7; t++) begin
      tick();
      if (t == 5) begin
        tests++;
        if (o_state !== 3'd4) begin
          failed++; $display("FAIL boundary_lock_last got %0d exp 4", o_state);
        end
        i_pll_lock = 1'b1;
      end
      if (t == 6) begin
        tests++;
        if (o_state !== 3'd5 || o_lock_err !== 1'b0) begin
          failed++; $display("FAIL boundary_no_err state %0d err %b exp 5 0", o_state, o_lock_err);
        end
      end
    end
    tests++;
    if (o_ack !== 1'b1 || o_lock_err !== 1'b0) begin
      failed++; $display("FAIL boundary_ack ack %b err %b exp 1 0", o_ack, o_lock_err);
    end
    i_req = 1'b0;
    i_pll_lock = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    int n;
    i_prep_cnt = 8'd0; i_pre_cnt = 8'd0; i_post_cnt = 8'd0; i_lock_to = 16'd20;
    i_pll_lock = 1'b0;
    i_req_vco_sel = 1'b1;
    i_req = 1'b1;
    repeat (5) tick();
    tests++;
    if (o_state !== 3'd4 || o_clk_gate !== 1'b1 || o_vco_sel !== 1'b1) begin
      failed++;
      $display("FAIL arst_pre state %0d gate %b vco %b exp 4 1 1", o_state, o_clk_gate, o_vco_sel);
    end
    i_rst_n = 1'b0;
    #1;
    tests++;
    if (o_clk_gate !== 1'b0 || o_vco_sel !== 1'b0 || o_state !== 3'd0 || o_busy !== 1'b0) begin
      failed++;
      $display("FAIL arst_async gate %b vco %b state %0d busy %b exp 0 0 0 0",
               o_clk_gate, o_vco_sel, o_state, o_busy);
    end
    i_req = 1'b0;
    repeat (2) tick();
    i_rst_n = 1'b1;
    tick();
    i_pll_lock = 1'b1;
    i_req = 1'b1;
    tick();
    tests++;
    if (o_state !== 3'd1) begin
      failed++; $display("FAIL arst_restart got %0d exp 1", o_state);
    end
    n = 0;
    while (o_ack !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (o_ack !== 1'b1 || n != 5) begin
      failed++; $display("FAIL arst_complete ack %b cycles %0d exp 1 5", o_ack, n);
    end
    i_req = 1'b0;
    tick();
    i_pll_lock = 1'b0;
  endtask

  task automatic test_req_drop();
    logic [2:0] exp_st;
    i_prep_cnt = 8'd1; i_pre_cnt = 8'd2; i_post_cnt = 8'd1; i_lock_to = 16'd8;
    i_pll_lock = 1'b1;
    i_req_vco_sel = 1'b0;
    i_req = 1'b1;
    for (int t = 0; t <= 10; t++) begin
      tick();
      exp_st = (t < 2) ? 3'd1 : (t < 5) ? 3'd2 : (t == 5) ? 3'd3 : (t == 6) ? 3'd4 :
               (t < 9) ? 3'd5 : (t == 9) ? 3'd6 : 3'd0;
      tests++;
      if (o_state !== exp_st || o_ack !== (t == 9) || o_busy !== (t < 10)) begin
        failed++;
        $display("FAIL drop_t%0d state %0d ack %b busy %b exp state %0d", t, o_state, o_ack, o_busy, exp_st);
      end
      if (t == 3) i_req = 1'b0;
    end
    i_pll_lock = 1'b0;
  endtask

  task automatic test_back_to_back();
    i_req_vco_sel = 1'b0;
    i_req = 1'b1;
    tick();
    tests++;
    if (o_state !== 3'd6) begin
      failed++; $display("FAIL b2b_first got %0d exp 6", o_state);
    end
    i_req = 1'b0;
    tick();
    i_req = 1'b1;
    tests++;
    if (o_state !== 3'd0 || o_ack !== 1'b0 || o_busy !== 1'b0) begin
      failed++; $display("FAIL b2b_idle state %0d ack %b busy %b exp 0 0 0", o_state, o_ack, o_busy);
    end
    tick();
    tests++;
    if (o_state !== 3'd6 || o_ack !== 1'b1) begin
      failed++; $display("FAIL b2b_second state %0d ack %b exp 6 1", o_state, o_ack);
    end
    i_req = 1'b0;
    tick();
  endtask

  initial begin
    tests = 0;
    failed = 0;
    i_rst_n = 1'b0;
    i_req = 1'b0;
    i_req_vco_sel = 1'b0;
    i_prep_cnt = '0;
    i_pre_cnt = '0;
    i_post_cnt = '0;
    i_lock_to = '0;
    i_pll_lock = 1'b0;
    i_err_clr = 1'b0;
    test_reset();
    test_same_vco();
    test_full_switch();
    test_lock_timeout();
    test_lock_boundary();
    test_async_reset();
    test_req_drop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
